// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise and filter the lines, deframe bytes, fold E0/F0 prefixes into events, queue them in a show-ahead FIFO.
// Define PS2_KBD_RX_PARITY_EN to reject frames with even parity.
module ps2_kbd_rx #(
    parameter int FILT_LEN = 4,
    parameter int TIMEOUT  = 50000,
    parameter int DEPTH    = 8,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2k_clk,
    input  logic          ps2k_data,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [7:0]    evt_code,
    output logic          evt_ext,
    output logic          evt_brk,
    output logic          ps2_state,
    output logic [AW:0]   fifo_count,
    output logic          err_frame,
    output logic          err_ovf
);

    localparam int GW = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    FILT_MAX = 4'(FILT_LEN - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(TIMEOUT);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_nx;
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk;
    logic [3:0]    filt_cnt;
    logic          fall;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [GW-1:0] gap_cnt;
    logic          timeout;
    logic          shift_en, par_en, stop_chk, start_err;
    logic          good_frame, bad_frame;
    logic          ext_flag, brk_flag;
    logic          push_req;
    logic [9:0]    push_word;
    logic          err_frame_r, err_ovf_r, state_r;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full, do_push, do_pop;
    logic [9:0]    head;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1 <= ps2k_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2k_data;
            dat_s2 <= dat_s1;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_MAX) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 4'd1;
            end
        end
    end

    // The filtered clock falls in exactly the cycle the last differing sample arrives.
    assign fall    = filt_clk & ~clk_s2 & (filt_cnt == FILT_MAX);
    assign timeout = (state != IDLE) && !fall && (gap_cnt == GAP_MAX);

    always_comb begin
        state_nx  = state;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop_chk  = 1'b0;
        start_err = 1'b0;
        case (state)
            IDLE: if (fall) begin
                if (!dat_s2) state_nx = DATA;
                else         start_err = 1'b1;
            end
            DATA: if (fall) begin
                shift_en = 1'b1;
                if (bit_cnt == 3'd7) state_nx = PARITY;
            end
            PARITY: if (fall) begin
                par_en   = 1'b1;
                state_nx = STOP;
            end
            STOP: if (fall) begin
                stop_chk = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (timeout) state_nx = IDLE;
    end

    assign good_frame = stop_chk & dat_s2 & par_ok;
    assign bad_frame  = stop_chk & ~good_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_ok      <= 1'b0;
            gap_cnt     <= '0;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
            push_req    <= 1'b0;
            push_word   <= '0;
            err_frame_r <= 1'b0;
        end else begin
            state       <= state_nx;
            push_req    <= 1'b0;
            err_frame_r <= start_err | bad_frame | timeout;
            if (state == IDLE || fall) gap_cnt <= '0;
            else                       gap_cnt <= gap_cnt + 1'b1;
            if (state == IDLE) bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shreg <= {dat_s2, shreg[7:1]};
            if (par_en) begin
`ifdef PS2_KBD_RX_PARITY_EN
                par_ok <= ^{shreg, dat_s2};
`else
                par_ok <= 1'b1;
`endif
            end
            // Prefix bytes only arm flags; any other good byte becomes an event next cycle.
            if (bad_frame || timeout) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (good_frame) begin
                if (shreg == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    push_req  <= 1'b1;
                    push_word <= {ext_flag, brk_flag, shreg};
                    ext_flag  <= 1'b0;
                    brk_flag  <= 1'b0;
                end
            end
        end
    end

    assign full    = (count == FULL_CNT);
    assign do_pop  = (count != '0) & evt_ready;
    assign do_push = push_req & (~full | do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            err_ovf_r <= 1'b0;
            state_r   <= 1'b0;
        end else begin
            err_ovf_r <= push_req & full & ~do_pop;
            if (do_push) begin
                wptr    <= wptr + 1'b1;
                state_r <= ~push_word[8];
            end
            if (do_pop) rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Outputs are forced low while reset is held, even before the first edge.
    assign evt_valid  = ~rst & (count != '0);
    assign evt_code   = rst ? 8'h00 : head[7:0];
    assign evt_brk    = ~rst & head[8];
    assign evt_ext    = ~rst & head[9];
    assign ps2_state  = ~rst & state_r;
    assign fifo_count = rst ? '0 : count;
    assign err_frame  = ~rst & err_frame_r;
    assign err_ovf    = ~rst & err_ovf_r;

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter FILT_LEN, 4, consecutive equal samples required before the filtered ps2k_clk changes (2..15).
REQ-002 Parameter TIMEOUT, 50000, clk cycles without a filtered ps2k_clk falling edge before an in-progress frame is aborted.
REQ-003 Parameter DEPTH, 8, event FIFO entries (power of 2, >=2); AW = log2(DEPTH).
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 ps2k_clk  in  1  PS/2 clock line, asynchronous.
REQ-007 ps2k_data  in  1  PS/2 data line, asynchronous.
REQ-008 evt_valid  out  1  FIFO head holds an event.
REQ-009 evt_ready  in  1  consumer accepts the head event.
REQ-010 evt_code  out  8  head event scan code.
REQ-011 evt_ext  out  1  head event was preceded by an E0 prefix.
REQ-012 evt_brk  out  1  head event was preceded by an F0 prefix (key release).
REQ-013 ps2_state  out  1  1 when the last pushed event was a make, 0 when it was a break.
REQ-014 fifo_count  out  AW+1  number of stored events.
REQ-015 err_frame  out  1  one-cycle pulse on a framing, parity or timeout error.
REQ-016 err_ovf  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-017 ps2k_clk and ps2k_data shall each pass through a 2-flop synchroniser; filtered clk shall change only after FILT_LEN consecutive equal synchronised samples.
REQ-018 A falling edge of filtered clk shall sample the synchronised ps2k_data in the same cycle.
REQ-019 Frame FSM states IDLE, DATA, PARITY, STOP: IDLE->DATA on an edge with data=0; an edge in IDLE with data=1 stays in IDLE and pulses err_frame.
REQ-020 DATA shall shift 8 bits LSB first, then go to PARITY; PARITY samples one bit, then STOP; STOP samples the stop bit, then IDLE.
REQ-021 A frame is good when stop=1 (plus the parity rule in REQ-035); a bad frame pulses err_frame, discards the byte and clears the prefix flags.
REQ-022 An edge-gap counter shall clear on every edge and in IDLE; reaching TIMEOUT outside IDLE forces IDLE, pulses err_frame and clears the prefix flags.
REQ-023 Good byte E0 shall set the ext flag, and good byte F0 shall set the brk flag; neither pushes an event.
REQ-024 Any other good byte shall push {ext, brk, byte} in the cycle after the STOP sample, then clear both flags.
REQ-025 Each push shall update ps2_state to ~brk.
REQ-026 The FIFO shall be show-ahead: evt_code, evt_ext and evt_brk reflect the head entry whenever evt_valid=1; evt_valid shall rise the cycle after a push into an empty FIFO.
REQ-027 A pop shall occur when evt_valid and evt_ready are both 1; evt_ready while empty shall have no effect.
REQ-028 A push while full without a simultaneous pop shall be dropped, pulse err_ovf and leave the contents unchanged.
REQ-029 A push and pop in the same cycle shall both take effect, with fifo_count unchanged, including when the FIFO is full.
REQ-030 Read and write pointers shall wrap modulo DEPTH; fifo_count ranges 0..DEPTH.

Reset
REQ-031 rst=1 at a rising clk edge shall set the FSM to IDLE, and clear the shift register, prefix flags, gap counter, FIFO pointers and filter state (filtered clk=1).
REQ-032 While rst=1 all outputs shall be 0: evt_valid, evt_code, evt_ext, evt_brk, ps2_state, fifo_count, err_frame and err_ovf.
REQ-033 Reset asserted mid-frame shall discard the partial frame; the first falling edge after release is treated as a start candidate.

Configuration
REQ-034 Macro PS2_KBD_RX_PARITY_EN selects parity checking.
REQ-035 When PS2_KBD_RX_PARITY_EN is defined, a frame whose 8 data bits plus the parity bit contain an even number of ones shall be bad (REQ-021).
REQ-036 When PS2_KBD_RX_PARITY_EN is undefined, the parity bit shall be sampled and ignored.

Verification
REQ-037 Make frame 0x1C, parity 0 -> one event code=1C ext=0 brk=0, ps2_state=1, fifo_count=1.
REQ-038 Frames F0, 1C -> exactly one event code=1C brk=1 ext=0, ps2_state=0.
REQ-039 Frames E0, F0, 75 -> one event code=75 ext=1 brk=1; the next frame 1C yields ext=0 brk=0.
REQ-040 DEPTH=8, evt_ready=0, 9 make frames 0x16..0x1E -> fifo_count=8, one err_ovf pulse; draining yields 16..1D in order and 1E is absent.
REQ-041 PS2_KBD_RX_PARITY_EN defined, frame 0x1C with parity 1 -> err_frame pulse, no event; with the macro undefined -> event 1C.
REQ-042 Clock stops after 5 data bits for TIMEOUT+1 cycles -> one err_frame pulse and return to IDLE; a following good frame 0x29 -> event 29.
